// File: rtl/ctrl_packet_initiator.sv
// ctrl_packet_initiator: host-side initiator for relative-addressed control packets.
// Issues one control beat per host request (hop in ChannelID, register address in
// State) and, for reads, waits for the absolute-addressed read response or a timeout.
// Optional statistics counters are enabled by defining CTRL_PACKET_INITIATOR_STATS_EN.
module ctrl_packet_initiator #(
    parameter int unsigned DATA_WIDTH                  = 512,
    parameter int unsigned STREAM_ID_NUM               = 16,
    parameter int unsigned CHUNK_ID_NUM                = 32,
    parameter int unsigned CHANNEL_ID_NUM              = 1024,
    parameter int unsigned STATE_WIDTH                 = 32,
    parameter int unsigned CP_R_CTRL_READ_REQUEST_32b  = 0,
    parameter int unsigned CP_R_CTRL_WRITE_32b         = 1,
    parameter int unsigned CP_A_CTRL_READ_RESPONSE_32b = 1,
    parameter int unsigned TIMEOUT_CYCLES              = 256,
    localparam int unsigned STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM),
    localparam int unsigned CHUNK_ID_WIDTH   = $clog2(CHUNK_ID_NUM),
    localparam int unsigned CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM)
) (
    input  logic                        clk,
    input  logic                        rst,
    // host request port
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [CHANNEL_ID_WIDTH-1:0] req_hop,
    input  logic [STREAM_ID_WIDTH-1:0]  req_stream,
    input  logic [STATE_WIDTH-1:0]      req_addr,
    input  logic [31:0]                 req_wdata,
    // forward path
    output logic [DATA_WIDTH-1:0]       out_Data,
    output logic [1:0]                  out_Type,
    output logic                        out_Last,
    output logic [STREAM_ID_WIDTH-1:0]  out_StreamID,
    output logic [CHUNK_ID_WIDTH-1:0]   out_ChunkID,
    output logic [CHANNEL_ID_WIDTH-1:0] out_ChannelID,
    output logic [STATE_WIDTH-1:0]      out_State,
    // return path
    input  logic [DATA_WIDTH-1:0]       in_Data,
    input  logic [1:0]                  in_Type,
    input  logic [STREAM_ID_WIDTH-1:0]  in_StreamID,
    input  logic [CHUNK_ID_WIDTH-1:0]   in_ChunkID,
    input  logic [STATE_WIDTH-1:0]      in_State,
    // host completion port
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_write,
    output logic                        rsp_timeout,
    output logic [31:0]                 rsp_data
`ifdef CTRL_PACKET_INITIATOR_STATS_EN
    ,
    output logic [15:0]                 stat_issued,
    output logic [15:0]                 stat_timeouts,
    output logic [15:0]                 stat_stray
`endif
);

    localparam int unsigned OPC_W  = CHUNK_ID_WIDTH - 1;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned LANES  = DATA_WIDTH / 32;

    localparam logic [OPC_W-1:0] OPC_RD  = OPC_W'(CP_R_CTRL_READ_REQUEST_32b);
    localparam logic [OPC_W-1:0] OPC_WR  = OPC_W'(CP_R_CTRL_WRITE_32b);
    localparam logic [OPC_W-1:0] OPC_RSP = OPC_W'(CP_A_CTRL_READ_RESPONSE_32b);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RESPOND  = 2'd3
    } state_t;

    state_t                       state;
    logic                         latWrite;
    logic [STREAM_ID_WIDTH-1:0]   latStream;
    logic [STATE_WIDTH-1:0]       latAddr;
    logic [CNT_W-1:0]             waitCnt;

    logic                         rspOpcodeBeat;
    logic                         rspTagMatch;
    logic                         rspMatch;
    logic                         timeoutHit;
    logic                         unusedBits;

    // Classify the return-path beat: absolute read response, and whether it belongs to us
    assign rspOpcodeBeat = in_Type[1] && !in_ChunkID[CHUNK_ID_WIDTH-1]
                           && (in_ChunkID[OPC_W-1:0] == OPC_RSP);
    assign rspTagMatch   = (in_StreamID == latStream) && (in_State == latAddr);
    assign rspMatch      = (state == WAIT_RSP) && rspOpcodeBeat && rspTagMatch;
    assign timeoutHit    = (state == WAIT_RSP) && !rspMatch && (waitCnt == CNT_LAST);

    // Only the low 32 bits of a response carry data; data-valid beats are never ours
    assign unusedBits = ^{in_Data[DATA_WIDTH-1:32], in_Type[0]};

    // Request FSM with registered packet and completion outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            out_Type      <= 2'b00;
            out_Last      <= 1'b0;
            out_Data      <= '0;
            out_StreamID  <= '0;
            out_ChunkID   <= '0;
            out_ChannelID <= '0;
            out_State     <= '0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_timeout   <= 1'b0;
            rsp_data      <= 32'h0;
            latWrite      <= 1'b0;
            latStream     <= '0;
            latAddr       <= '0;
            waitCnt       <= '0;
        end else begin
            out_Type <= 2'b00;
            out_Last <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        latWrite      <= req_write;
                        latStream     <= req_stream;
                        latAddr       <= req_addr;
                        out_Type      <= 2'b10;
                        out_Last      <= 1'b1;
                        out_ChunkID   <= {1'b1, (req_write ? OPC_WR : OPC_RD)};
                        out_ChannelID <= req_hop;
                        out_StreamID  <= req_stream;
                        out_State     <= req_addr;
                        out_Data      <= req_write ? {LANES{req_wdata}} : '0;
                        req_ready     <= 1'b0;
                        state         <= ISSUE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (latWrite) begin
                        rsp_valid   <= 1'b1;
                        rsp_write   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_data    <= 32'h0;
                        state       <= RESPOND;
                    end else begin
                        waitCnt <= '0;
                        state   <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    waitCnt <= waitCnt + CNT_W'(1);
                    if (rspMatch) begin
                        rsp_valid   <= 1'b1;
                        rsp_write   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_data    <= in_Data[31:0];
                        state       <= RESPOND;
                    end else if (timeoutHit) begin
                        rsp_valid   <= 1'b1;
                        rsp_write   <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_data    <= 32'hFFFF_FFFF;
                        state       <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CTRL_PACKET_INITIATOR_STATS_EN
    logic strayBeat;

    // A response-opcode beat is stray unless it is the one we are waiting for
    assign strayBeat = rspOpcodeBeat && ((state != WAIT_RSP) || !rspTagMatch);

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued   <= 16'h0;
            stat_timeouts <= 16'h0;
            stat_stray    <= 16'h0;
        end else begin
            if ((state == ISSUE) && (stat_issued != 16'hFFFF)) begin
                stat_issued <= stat_issued + 16'd1;
            end
            if (timeoutHit && (stat_timeouts != 16'hFFFF)) begin
                stat_timeouts <= stat_timeouts + 16'd1;
            end
            if (strayBeat && (stat_stray != 16'hFFFF)) begin
                stat_stray <= stat_stray + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_packet_initiator.sv
// Directed bench for ctrl_packet_initiator: vector table of requests plus
// hand-written timeout, expiry-race, back-pressure and mid-read reset sequences.
module tb_ctrl_packet_initiator;

    localparam int unsigned DW = 512;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 5;
    localparam int unsigned HW = 10;
    localparam int unsigned TW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [HW-1:0] req_hop = '0;
    logic [SW-1:0] req_stream = '0;
    logic [TW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [DW-1:0] out_Data;
    logic [1:0]    out_Type;
    logic          out_Last;
    logic [SW-1:0] out_StreamID;
    logic [CW-1:0] out_ChunkID;
    logic [HW-1:0] out_ChannelID;
    logic [TW-1:0] out_State;
    logic [DW-1:0] in_Data = '0;
    logic [1:0]    in_Type = 2'b00;
    logic [SW-1:0] in_StreamID = '0;
    logic [CW-1:0] in_ChunkID = '0;
    logic [TW-1:0] in_State = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_write;
    logic          rsp_timeout;
    logic [31:0]   rsp_data;
`ifdef CTRL_PACKET_INITIATOR_STATS_EN
    logic [15:0]   stat_issued;
    logic [15:0]   stat_timeouts;
    logic [15:0]   stat_stray;
`endif

    always #5 clk = ~clk;

    ctrl_packet_initiator dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_hop      (req_hop),
        .req_stream   (req_stream),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .out_Data     (out_Data),
        .out_Type     (out_Type),
        .out_Last     (out_Last),
        .out_StreamID (out_StreamID),
        .out_ChunkID  (out_ChunkID),
        .out_ChannelID(out_ChannelID),
        .out_State    (out_State),
        .in_Data      (in_Data),
        .in_Type      (in_Type),
        .in_StreamID  (in_StreamID),
        .in_ChunkID   (in_ChunkID),
        .in_State     (in_State),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_write    (rsp_write),
        .rsp_timeout  (rsp_timeout),
        .rsp_data     (rsp_data)
`ifdef CTRL_PACKET_INITIATOR_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_timeouts(stat_timeouts),
        .stat_stray   (stat_stray)
`endif
    );

    typedef struct {
        logic          write;
        logic [HW-1:0] hop;
        logic [SW-1:0] stream;
        logic [TW-1:0] addr;
        logic [31:0]   wdata;
        int            delay;
        logic [31:0]   rdata;
        logic [CW-1:0] expChunk;
        logic [31:0]   expRsp;
    } vec_t;

    int nCmp  = 0;
    int nFail = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBeat(input logic [1:0] t, input logic [CW-1:0] chunk,
                            input logic [SW-1:0] sid, input logic [TW-1:0] st,
                            input logic [31:0] d);
        in_Type     = t;
        in_ChunkID  = chunk;
        in_StreamID = sid;
        in_State    = st;
        in_Data     = {{(DW-32){1'b1}}, d};
        step();
        in_Type     = 2'b00;
        in_ChunkID  = '0;
        in_StreamID = '0;
        in_State    = '0;
        in_Data     = '0;
    endtask

    // Handshake one request, check the control beat, and return in the cycle after ISSUE
    task automatic issue(input logic w, input logic [HW-1:0] hop, input logic [SW-1:0] sid,
                         input logic [TW-1:0] addr, input logic [31:0] wd,
                         input logic [CW-1:0] expChunk);
        logic [DW-1:0] expD;
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        chk("req_ready_before_issue", DW'(req_ready), DW'(1));
        req_write  = w;
        req_hop    = hop;
        req_stream = sid;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
        expD = '0;
        if (w) begin
            for (int i = 0; i < 16; i++) expD[i*32 +: 32] = wd;
        end
        chk("issue_out_Type", DW'(out_Type), DW'(2'b10));
        chk("issue_out_Last", DW'(out_Last), DW'(1));
        chk("issue_out_ChunkID", DW'(out_ChunkID), DW'(expChunk));
        chk("issue_out_ChannelID", DW'(out_ChannelID), DW'(hop));
        chk("issue_out_StreamID", DW'(out_StreamID), DW'(sid));
        chk("issue_out_State", DW'(out_State), DW'(addr));
        chk("issue_out_Data", out_Data, expD);
        chk("issue_req_ready_low", DW'(req_ready), DW'(0));
        step();
        chk("post_issue_out_Type", DW'(out_Type), DW'(0));
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{write: 1'b1, hop: 10'd3,    stream: 4'd2,  addr: 32'h10,        wdata: 32'hA5A5_0001,
                    delay: 0,  rdata: 32'h0,          expChunk: 5'b10001, expRsp: 32'h0};
        vecs[1] = '{write: 1'b0, hop: 10'd0,    stream: 4'd5,  addr: 32'h24,        wdata: 32'h0,
                    delay: 10, rdata: 32'hCAFE_F00D,  expChunk: 5'b10000, expRsp: 32'hCAFE_F00D};
        vecs[2] = '{write: 1'b1, hop: 10'd1023, stream: 4'd15, addr: 32'hFFFF_FFFF, wdata: 32'h1234_5678,
                    delay: 0,  rdata: 32'h0,          expChunk: 5'b10001, expRsp: 32'h0};
        vecs[3] = '{write: 1'b0, hop: 10'd7,    stream: 4'd0,  addr: 32'h0,         wdata: 32'h0,
                    delay: 0,  rdata: 32'h0BAD_BEEF,  expChunk: 5'b10000, expRsp: 32'h0BAD_BEEF};

        // reset state
        step(2);
        chk("rst_out_Type", DW'(out_Type), DW'(0));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_rsp_timeout", DW'(rsp_timeout), DW'(0));
        chk("rst_rsp_write", DW'(rsp_write), DW'(0));
        chk("rst_rsp_data", DW'(rsp_data), DW'(0));
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        rst = 1'b0;
        step();
        chk("post_rst_req_ready", DW'(req_ready), DW'(1));

        // table-driven requests
        for (int i = 0; i < 4; i++) begin
            issue(vecs[i].write, vecs[i].hop, vecs[i].stream, vecs[i].addr, vecs[i].wdata,
                  vecs[i].expChunk);
            if (!vecs[i].write) begin
                if (vecs[i].delay > 0) step(vecs[i].delay);
                chk("vec_no_early_rsp", DW'(rsp_valid), DW'(0));
                sendBeat(2'b10, 5'b00001, vecs[i].stream, vecs[i].addr, vecs[i].rdata);
            end
            chk("vec_rsp_valid", DW'(rsp_valid), DW'(1));
            chk("vec_rsp_write", DW'(rsp_write), DW'(vecs[i].write));
            chk("vec_rsp_data", DW'(rsp_data), DW'(vecs[i].expRsp));
            chk("vec_rsp_timeout", DW'(rsp_timeout), DW'(0));
            step();
            chk("vec_done_rsp_valid", DW'(rsp_valid), DW'(0));
            chk("vec_done_req_ready", DW'(req_ready), DW'(1));
        end

        // read with no response: completion 256 cycles after entering WAIT_RSP
        issue(1'b0, 10'd4, 4'd1, 32'h40, 32'h0, 5'b10000);
        step(255);
        chk("to_not_yet", DW'(rsp_valid), DW'(0));
        step();
        chk("to_rsp_valid", DW'(rsp_valid), DW'(1));
        chk("to_rsp_timeout", DW'(rsp_timeout), DW'(1));
        chk("to_rsp_data", DW'(rsp_data), DW'(32'hFFFF_FFFF));
        chk("to_rsp_write", DW'(rsp_write), DW'(0));
        step();
        chk("to_done_req_ready", DW'(req_ready), DW'(1));

        // ignored beats, then a match on the expiry cycle
        issue(1'b0, 10'd0, 4'd5, 32'h24, 32'h0, 5'b10000);
        sendBeat(2'b10, 5'b00001, 4'd6, 32'h24, 32'h1111_1111);
        sendBeat(2'b10, 5'b00001, 4'd5, 32'h28, 32'h2222_2222);
        sendBeat(2'b01, 5'b00001, 4'd5, 32'h24, 32'h3333_3333);
        sendBeat(2'b10, 5'b10001, 4'd5, 32'h24, 32'h4444_4444);
        chk("race_ignored", DW'(rsp_valid), DW'(0));
        step(251);
        chk("race_not_yet", DW'(rsp_valid), DW'(0));
        sendBeat(2'b10, 5'b00001, 4'd5, 32'h24, 32'h600D_DA7A);
        chk("race_rsp_valid", DW'(rsp_valid), DW'(1));
        chk("race_rsp_timeout", DW'(rsp_timeout), DW'(0));
        chk("race_rsp_data", DW'(rsp_data), DW'(32'h600D_DA7A));
        step();
        chk("race_done_rsp_valid", DW'(rsp_valid), DW'(0));

        // host back-pressure holds the completion and blocks new requests
        rsp_ready = 1'b0;
        issue(1'b0, 10'd2, 4'd9, 32'h100, 32'h0, 5'b10000);
        sendBeat(2'b10, 5'b00001, 4'd9, 32'h100, 32'h1357_9BDF);
        chk("bp_rsp_valid", DW'(rsp_valid), DW'(1));
        req_write = 1'b1;
        req_hop   = 10'd1;
        req_addr  = 32'h200;
        req_wdata = 32'hDEAD_0000;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_hold_valid", DW'(rsp_valid), DW'(1));
            chk("bp_hold_data", DW'(rsp_data), DW'(32'h1357_9BDF));
            chk("bp_hold_req_ready", DW'(req_ready), DW'(0));
            chk("bp_hold_out_Type", DW'(out_Type), DW'(0));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("bp_rel_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("bp_rel_req_ready", DW'(req_ready), DW'(1));
        chk("bp_rel_out_Type", DW'(out_Type), DW'(0));

`ifdef CTRL_PACKET_INITIATOR_STATS_EN
        chk("stat_issued", DW'(stat_issued), DW'(7));
        chk("stat_timeouts", DW'(stat_timeouts), DW'(1));
        chk("stat_stray", DW'(stat_stray), DW'(2));
`endif

        // reset during WAIT_RSP, then a late response
        issue(1'b0, 10'd5, 4'd3, 32'h80, 32'h0, 5'b10000);
        step(5);
        rst = 1'b1;
        step();
        chk("mid_rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("mid_rst_req_ready", DW'(req_ready), DW'(0));
        chk("mid_rst_out_Type", DW'(out_Type), DW'(0));
        rst = 1'b0;
        step();
        chk("after_rst_req_ready", DW'(req_ready), DW'(1));
        sendBeat(2'b10, 5'b00001, 4'd3, 32'h80, 32'h5555_AAAA);
        chk("late_rsp_dropped", DW'(rsp_valid), DW'(0));
        step(3);
        chk("late_rsp_still_dropped", DW'(rsp_valid), DW'(0));
        chk("late_req_ready", DW'(req_ready), DW'(1));
`ifdef CTRL_PACKET_INITIATOR_STATS_EN
        chk("late_stat_stray", DW'(stat_stray), DW'(1));
        chk("late_stat_issued", DW'(stat_issued), DW'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/ctrl_packet_initiator.md
Name: ctrl_packet_initiator

Overview:
- Host-side initiator for the stream pipeline's relative-addressed control protocol.
- Accepts single read/write requests from a host port and emits one relative-addressed control packet on the forward path:
  - ChannelID = hop count to the target module.
  - State = register address.
- For reads, it watches the return path for the matching absolute-addressed CTRL_READ_RESPONSE_32b packet and hands the data back to the host, with a timeout.
- Sits at the head/tail of a module chain, in front of the first processing element.

Parameters:
- DATA_WIDTH, 512: forward data bus width, a multiple of 32.
- STREAM_ID_NUM, 16: number of virtual streams.
- CHUNK_ID_NUM, 32: chunk ID space. MSB selects relative (1) or absolute (0) addressing; the low bits carry the opcode.
- CHANNEL_ID_NUM, 1024: channel ID space. Used as the hop selector on relative packets.
- STATE_WIDTH, 32: state/address field width.
- CP_R_CTRL_READ_REQUEST_32b, 0: relative opcode for a read.
- CP_R_CTRL_WRITE_32b, 1: relative opcode for a write.
- CP_A_CTRL_READ_RESPONSE_32b, 1: absolute opcode for a read response.
- TIMEOUT_CYCLES, 256: maximum wait cycles for a read response (≥2).
- Derived widths: STREAM_ID_WIDTH, CHUNK_ID_WIDTH and CHANNEL_ID_WIDTH, each the $clog2 of its count.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- req_valid, in, 1: host request valid.
- req_ready, out, 1: high only in IDLE.
- req_write, in, 1: 1 = write, 0 = read.
- req_hop, in, CHANNEL_ID_WIDTH: target module index (0 = first module).
- req_stream, in, STREAM_ID_WIDTH: stream ID for the packet.
- req_addr, in, STATE_WIDTH: register address.
- req_wdata, in, 32: write value.
- out_Data, out, DATA_WIDTH: forward data.
- out_Type, out, 2: bit1 = control valid, bit0 = data valid.
- out_Last, out, 1: last flag.
- out_StreamID, out, STREAM_ID_WIDTH: stream ID.
- out_ChunkID, out, CHUNK_ID_WIDTH: chunk ID.
- out_ChannelID, out, CHANNEL_ID_WIDTH: channel ID.
- out_State, out, STATE_WIDTH: state field.
- in_Data, in, DATA_WIDTH: return-path data.
- in_Type, in, 2: return-path type.
- in_StreamID, in, STREAM_ID_WIDTH: return-path stream ID.
- in_ChunkID, in, CHUNK_ID_WIDTH: return-path chunk ID.
- in_State, in, STATE_WIDTH: return-path state field.
- rsp_valid, out, 1: completion valid.
- rsp_ready, in, 1: host accepts the completion.
- rsp_write, out, 1: completion belongs to a write.
- rsp_timeout, out, 1: read timed out.
- rsp_data, out, 32: read data.

Behaviour:
- **Reset (synchronous, `rst`=1):** state = IDLE, `out_Type`=0, `rsp_valid`=0, `rsp_timeout`=0, `rsp_write`=0, `rsp_data`=0, timeout counter = 0, `req_ready`=0 during the reset cycle.
  - All other out_* fields are don't-care while `out_Type`=0.
  - Reset mid-operation discards the outstanding request; a late response is then treated as stray.
- **States:** IDLE, ISSUE, WAIT_RSP, RESPOND.
- **IDLE:** `req_ready`=1. On `req_valid`: latch the request and go to ISSUE.
- **ISSUE (one cycle):** packet is registered, so it is visible on the out_* ports the cycle after the request handshake.
  - `out_Type`=2'b10, `out_Last`=1.
  - `out_ChunkID` = {1'b1, opcode}.
  - `out_ChannelID` = hop, `out_StreamID` = stream, `out_State` = addr.
  - `out_Data` = wdata replicated into every 32-bit field for a write; all zeros for a read.
  - Write → RESPOND with `rsp_write`=1, `rsp_data`=0 (posted).
  - Read → WAIT_RSP with the counter cleared.
- **out_Type outside ISSUE:** 0 in every other cycle; exactly one control beat per request.
- **Response match (in WAIT_RSP), all must hold:**
  - `in_Type[1]`=1
  - `in_ChunkID` MSB=0
  - low bits = CP_A_CTRL_READ_RESPONSE_32b
  - `in_StreamID` = latched stream
  - `in_State` = latched addr
- **WAIT_RSP:**
  - Match → capture `in_Data[31:0]` into `rsp_data`, `rsp_timeout`=0, go to RESPOND; `rsp_valid` rises the cycle after the matching beat.
  - Non-matching beats are ignored.
  - Counter increments each cycle. At counter = TIMEOUT_CYCLES-1 with no match: `rsp_timeout`=1, `rsp_data`=32'hFFFF_FFFF, go to RESPOND.
  - Match in the same cycle as timeout expiry: the match wins (`rsp_timeout`=0).
- **RESPOND:** `rsp_valid`=1 and payload held stable until `rsp_ready`. On handshake go to IDLE; `req_ready`=1 the following cycle.
  - Responses arriving in any state other than WAIT_RSP are dropped.
- **Single outstanding request; throughput:**
  - Write: 3 cycles minimum per request.
  - Read: response latency + 3.
- **Width rules:** `req_hop` is used unmodified; decrementing it is the responders' job. Hop 0 addresses the first module.

Optional Feature:
- Macro: CTRL_PACKET_INITIATOR_STATS_EN.
- When defined, three 16-bit saturating outputs are added, each cleared by `rst`:
  - `stat_issued`: increments per ISSUE cycle.
  - `stat_timeouts`: increments per timeout.
  - `stat_stray`: increments per response-opcode beat that is dropped, i.e. a beat received outside WAIT_RSP or one with a stream/addr mismatch.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Write: hop=3, stream=2, addr=0x10, wdata=0xA5A5_0001.
   - Next cycle: `out_Type`=2'b10, `out_ChunkID`=5'b10001, `out_ChannelID`=3, `out_State`=0x10, all 16 fields of `out_Data` = 0xA5A5_0001.
   - Following cycle: `rsp_valid`=1 with `rsp_write`=1.
2. Read: hop=0, addr=0x24, stream=5. Responder returns ChunkID=5'b00001, stream 5, State=0x24, Data[31:0]=0xCAFE_F00D after 10 cycles.
   - `rsp_valid`=1 one cycle later with `rsp_data`=0xCAFE_F00D, `rsp_timeout`=0.
3. Read with no response, TIMEOUT_CYCLES=256.
   - `rsp_timeout`=1, `rsp_data`=0xFFFF_FFFF exactly 256 cycles after entering WAIT_RSP.
4. Read where the response arrives exactly on the expiry cycle → data is returned with `rsp_timeout`=0.
   - Same run, prior stimulus: responses with wrong stream (6), then wrong State (0x28), then data-type beats → all ignored.
5. `rsp_ready` held low for 20 cycles → `rsp_valid` and `rsp_data` stay stable, `req_ready`=0, no new packet is issued.
6. Assert `rst` during WAIT_RSP, then inject the late response.
   - Required: `rsp_valid` never asserts, `req_ready`=1 after reset.
   - With STATS_EN: `stat_stray`=1.
